alu_seq_16bit: RTL and testbench
================================

ALU_SEQ_16BIT -- requirements
Module: alu_seq_16bit

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit slices processed per operation (operand width W = 4*NIBBLES).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 a  input  W  SHALL be operand A, latched on an accepted start.
REQ-006 b  input  W  SHALL be operand B, latched on an accepted start.
REQ-007 s  input  4  SHALL be the ALU function select, latched on an accepted start.
REQ-008 m  input  1  SHALL be the mode (0 arithmetic, 1 logic), latched on an accepted start.
REQ-009 cin  input  1  SHALL be the carry into nibble 0, latched on an accepted start.
REQ-010 busy  output  1  SHALL be high in RUN and DONE.
REQ-011 done  output  1  SHALL pulse high for exactly one cycle when result and cout are valid.
REQ-012 result  output  W  SHALL be the registered W-bit result.
REQ-013 cout  output  1  SHALL be the registered carry out of the top nibble.

Function
REQ-014 The block SHALL contain exactly one alu_4bit instance and SHALL time-share it across all nibbles.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE with start=1 at edge k: latch a, b, s, m, cin; nibble index <= 0; carry register <= cin; go to RUN.
REQ-017 RUN, each cycle: drive ALU with nibble[idx] of latched a/b, latched s/m, carry register; at the edge write ALU output to result[4*idx+3:4*idx], carry register <= ALU cout, idx <= idx+1.
REQ-018 RUN at idx = NIBBLES-1: after the write, cout <= ALU cout; go to DONE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 Latency: start sampled at edge k -> done high during the cycle after edge k+NIBBLES.
REQ-021 start in RUN or DONE SHALL be ignored and SHALL NOT alter latched operands; back-to-back ops need start in IDLE (throughput one op per NIBBLES+2 cycles).
REQ-022 Input changes on a, b, s, m, cin after acceptance SHALL NOT affect the running operation.
REQ-023 In logic mode (m=1), the carry chain SHALL propagate the ALU cout (0), so final cout = 0.
REQ-024 result and cout SHALL hold their values from DONE until the next accepted operation writes them.
REQ-025 The nibble index SHALL never exceed NIBBLES-1; no wrap-around into a second pass.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, idx 0, carry register 0, result 0, cout 0, done 0, busy 0, including mid-operation.
REQ-027 After rst_n release, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-028 With ALU_SEQ_ZERO_EN defined, output zero (1 bit) SHALL exist, registered, set in DONE to (result == 0), held like result, reset to 0.
REQ-029 Without ALU_SEQ_ZERO_EN, port zero and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 m=0 s=1001 cin=0 a=0x1234 b=0x0FFF -> done after 4 cycles, result=0x2233, cout=0.
REQ-031 m=0 s=1001 cin=0 a=0xFFFF b=0x0001 -> result=0x0000, cout=1, zero=1 (macro on).
REQ-032 m=0 s=0110 cin=1 a=0x0005 b=0x0003 (subtract) -> result=0x0002, cout=1.
REQ-033 m=1 s=0110 (XOR) a=0xF0F0 b=0xFF00 -> result=0x0FF0, cout=0.
REQ-034 start pulsed with a=0x1111 during RUN of REQ-030 -> ignored; result=0x2233, single done pulse.
REQ-035 rst_n low at cycle 2 of RUN -> busy=0, done=0, result=0x0000 immediately; next start completes normally.

Source files
------------

// File: rtl/alu_seq_16bit_if.sv
// ---------------------------------------------------------------------------
// alu_seq_16bit_if
// Bundles the operation request and result signals of alu_seq_16bit.
//   start            : request an operation (sampled only while idle)
//   a, b             : operands, W = 4*NIBBLES bits
//   s, m, cin        : function select, mode (0 arith / 1 logic), carry in
//   busy, done       : busy during RUN/DONE, one-cycle done pulse
//   result, cout     : registered result and carry out of the top nibble
//   zero             : result == 0 flag, present only with ALU_SEQ_ZERO_EN
// Modports: master drives the request, slave is the sequential ALU.
// Optional feature macro: ALU_SEQ_ZERO_EN
// ---------------------------------------------------------------------------
interface alu_seq_16bit_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef ALU_SEQ_ZERO_EN
    logic         zero;

    modport master (output start, a, b, s, m, cin,
                    input  busy, done, result, cout, zero);
    modport slave  (input  start, a, b, s, m, cin,
                    output busy, done, result, cout, zero);
`else
    modport master (output start, a, b, s, m, cin,
                    input  busy, done, result, cout);
    modport slave  (input  start, a, b, s, m, cin,
                    output busy, done, result, cout);
`endif
endinterface

// File: rtl/alu_seq_16bit.sv
// ---------------------------------------------------------------------------
// alu_seq_16bit
// Nibble-serial ALU: one 4-bit 74181-style ALU slice is time-shared over
// NIBBLES nibbles, least significant first, with the carry kept in a register
// between slices. Latency from accepted start to done is NIBBLES+1 cycles.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : alu_seq_16bit_if.slave (start, a, b, s, m, cin in;
//            busy, done, result, cout [, zero] out)
// Optional feature macro: ALU_SEQ_ZERO_EN adds the registered zero flag.
// ---------------------------------------------------------------------------

// 4-bit ALU slice with 74181 function table, active-high data and carry.
// Arithmetic: F = X + Y + cin where X/Y are the select-gated terms of the
// 74181 carry-lookahead cell; logic: F = ~(X ^ Y), carry out forced to 0.
module alu_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout
);
    logic [3:0] x_s;
    logic [3:0] y_s;
    logic [4:0] sum_s;

    // Slice function: gated terms, 5-bit sum, then mode selection
    always_comb begin
        x_s   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y_s   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum_s = {1'b0, x_s} + {1'b0, y_s} + {4'b0000, cin};
        if (m) begin
            f    = ~(x_s ^ y_s);
            cout = 1'b0;
        end else begin
            f    = sum_s[3:0];
            cout = sum_s[4];
        end
    end
endmodule

module alu_seq_16bit #(
    parameter int NIBBLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_16bit_if.slave bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_r;
    logic [IDXW-1:0] idx_r;
    logic            carry_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [3:0]      s_r;
    logic            m_r;
    logic [W-1:0]    result_r;
    logic            cout_r;
    logic            done_r;
    logic            busy_r;
`ifdef ALU_SEQ_ZERO_EN
    logic            zero_r;
`endif

    logic [3:0]      a_nib_s;
    logic [3:0]      b_nib_s;
    logic [3:0]      alu_f_s;
    logic            alu_cout_s;
    logic [W-1:0]    result_nxt_s;
    logic            last_s;

    // Select the current nibble of the latched operands and merge the slice
    // output into the result; the merged word also feeds the zero flag so it
    // is valid in the same cycle as done.
    always_comb begin
        a_nib_s      = a_r[{idx_r, 2'b00} +: 4];
        b_nib_s      = b_r[{idx_r, 2'b00} +: 4];
        result_nxt_s = result_r;
        result_nxt_s[{idx_r, 2'b00} +: 4] = alu_f_s;
        last_s       = (idx_r == LAST_IDX);
    end

    alu_4bit u_alu (
        .a    (a_nib_s),
        .b    (b_nib_s),
        .s    (s_r),
        .m    (m_r),
        .cin  (carry_r),
        .f    (alu_f_s),
        .cout (alu_cout_s)
    );

    // Control FSM, operand latches, nibble sequencing and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            s_r      <= 4'b0000;
            m_r      <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
`ifdef ALU_SEQ_ZERO_EN
            zero_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        s_r     <= bus.s;
                        m_r     <= bus.m;
                        carry_r <= bus.cin;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_r <= result_nxt_s;
                    carry_r  <= alu_cout_s;
                    if (last_s) begin
                        // Index parks at 0 so it never runs past the top nibble
                        cout_r  <= alu_cout_s;
                        idx_r   <= '0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
`ifdef ALU_SEQ_ZERO_EN
                        zero_r  <= (result_nxt_s == '0);
`endif
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    idx_r   <= '0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
`ifdef ALU_SEQ_ZERO_EN
    assign bus.zero   = zero_r;
`endif

endmodule

// File: tb/tb_alu_seq_16bit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_16bit
// Self-checking bench for alu_seq_16bit (NIBBLES = 4). Expected results come
// from a full-width 74181 function table and are queued when an operation is
// issued, then popped when done is seen.
// Zero flag is checked only when ALU_SEQ_ZERO_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_seq_16bit;
    localparam int NIBBLES = 4;

    typedef struct packed {
        logic [15:0] result;
        logic        cout;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    exp_t exp_q[$];

    alu_seq_16bit_if #(.NIBBLES(NIBBLES)) bus ();

    alu_seq_16bit #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Full-width reference: 74181 tables, active-high data and carry
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] s, input logic m,
                                   input logic cin);
        exp_t        e;
        logic [15:0] p;
        logic [15:0] q;
        logic [16:0] sum;
        if (m) begin
            case (s)
                4'd0:    p = ~a;
                4'd1:    p = ~(a | b);
                4'd2:    p = ~a & b;
                4'd3:    p = 16'h0000;
                4'd4:    p = ~(a & b);
                4'd5:    p = ~b;
                4'd6:    p = a ^ b;
                4'd7:    p = a & ~b;
                4'd8:    p = ~a | b;
                4'd9:    p = ~(a ^ b);
                4'd10:   p = b;
                4'd11:   p = a & b;
                4'd12:   p = 16'hFFFF;
                4'd13:   p = a | ~b;
                4'd14:   p = a | b;
                default: p = a;
            endcase
            e.result = p;
            e.cout   = 1'b0;
        end else begin
            case (s)
                4'd0:    begin p = a;       q = 16'h0000; end
                4'd1:    begin p = a | b;   q = 16'h0000; end
                4'd2:    begin p = a | ~b;  q = 16'h0000; end
                4'd3:    begin p = 16'h0000; q = 16'hFFFF; end
                4'd4:    begin p = a;       q = a & ~b;   end
                4'd5:    begin p = a | b;   q = a & ~b;   end
                4'd6:    begin p = a;       q = ~b;       end
                4'd7:    begin p = a & ~b;  q = 16'hFFFF; end
                4'd8:    begin p = a;       q = a & b;    end
                4'd9:    begin p = a;       q = b;        end
                4'd10:   begin p = a | ~b;  q = a & b;    end
                4'd11:   begin p = a & b;   q = 16'hFFFF; end
                4'd12:   begin p = a;       q = a;        end
                4'd13:   begin p = a | b;   q = a;        end
                4'd14:   begin p = a | ~b;  q = a;        end
                default: begin p = a;       q = 16'hFFFF; end
            endcase
            sum      = {1'b0, p} + {1'b0, q} + {16'h0000, cin};
            e.result = sum[15:0];
            e.cout   = sum[16];
        end
        e.zero = (e.result == 16'h0000);
        return e;
    endfunction

    // Issue one op from a negedge; optionally poke start/a during RUN.
    task automatic run_op(input string tag, input logic [15:0] a_v,
                          input logic [15:0] b_v, input logic [3:0] s_v,
                          input logic m_v, input logic cin_v, input bit poke);
        exp_t e;
        exp_t got;
        int   n_done;
        int   lat;
        e = model(a_v, b_v, s_v, m_v, cin_v);
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.s     = s_v;
        bus.m     = m_v;
        bus.cin   = cin_v;
        @(negedge clk);
        // Scramble inputs after acceptance; the running op must not see them
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.s     = 4'($urandom);
        bus.m     = 1'($urandom);
        bus.cin   = 1'($urandom);
        check_val({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        n_done = 0;
        lat    = 0;
        for (int i = 1; i <= 8; i++) begin
            bus.start = (poke && i == 2);
            if (poke && i == 2) bus.a = 16'h1111;
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin
                    lat = i;
                    if (exp_q.size() > 0) begin
                        got = exp_q.pop_front();
                        check_val({tag, "_result"}, {16'd0, bus.result}, {16'd0, got.result});
                        check_val({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, got.cout});
`ifdef ALU_SEQ_ZERO_EN
                        check_val({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, got.zero});
`endif
                    end
                end
            end
        end
        bus.start = 1'b0;
        check_val({tag, "_ndone"}, n_done, 32'd1);
        check_val({tag, "_latency"}, lat, NIBBLES);
        check_val({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        check_val({tag, "_hold"}, {15'd0, bus.result, bus.cout}, {15'd0, e.result, e.cout});
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        bus.s     = 4'h0;
        bus.m     = 1'b0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_done", {31'd0, bus.done}, 32'd0);
        check_val("rst_result", {16'd0, bus.result}, 32'd0);
        check_val("rst_cout", {31'd0, bus.cout}, 32'd0);
        rst_n = 1'b1;

        // Start on the first edge after reset release
        run_op("add", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
        run_op("sub", 16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b1, 1'b0);
        run_op("xor", 16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 1'b0);
        run_op("poke", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b1);

        // Reset during the second RUN cycle of an op
        bus.start = 1'b1;
        bus.a     = 16'hABCD;
        bus.b     = 16'h1357;
        bus.s     = 4'b1001;
        bus.m     = 1'b0;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("midrst_done", {31'd0, bus.done}, 32'd0);
        check_val("midrst_result", {16'd0, bus.result}, 32'd0);
        check_val("midrst_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 1'b0);

        // Random ops across every select and both modes
        for (int k = 0; k < 16; k++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 4'(k), 1'($urandom),
                   1'($urandom), 1'b0);
        end

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
